// File: rtl/mips_pkg.sv
// Shared encodings for the data-memory access path: access sizes and FSM states.
// No logic; constants and a small size-normalising helper only.
// Imported by mem_access_unit and mem_align.
package mips_pkg;

    // Access size encodings carried on mem_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Memory access FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // The unused 2'b11 size code behaves exactly like a word access
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for stores, byte enables, alignment check and load extraction/extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs. Sub-word support only with MAU_SUBWORD_EN defined.
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_dat,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_ext
);

`ifdef MAU_SUBWORD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate data across lanes and pick the enables for the addressed lane(s)
    always_comb begin
        st_be       = 4'b1111;
        st_lane_dat = st_wdata;
        misaligned  = 1'b0;
        case (norm_size(st_size))
            SZ_BYTE: begin
                st_be       = 4'b0001 << st_lo;
                st_lane_dat = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be       = st_lo[1] ? 4'b1100 : 4'b0011;
                st_lane_dat = {2{st_wdata[15:0]}};
                misaligned  = st_lo[0];
            end
            default: begin
                st_be       = 4'b1111;
                st_lane_dat = st_wdata;
                misaligned  = |st_lo;
            end
        endcase
    end

    // Load side: select the addressed lane and sign- or zero-extend it
    always_comb begin
        case (ld_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (norm_size(ld_size))
            SZ_BYTE: ld_ext = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = ld_rdata;
        endcase
    end
`else
    logic unused_subword;

    // Word-only build: every access is a full word; size and extension controls are ignored
    assign st_be          = 4'b1111;
    assign st_lane_dat    = st_wdata;
    assign misaligned     = |st_lo;
    assign ld_ext         = ld_rdata;
    assign unused_subword = ^{st_size, ld_size, ld_unsigned, ld_lo};
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access FSM (IDLE/BUSY/DONE) between EX/MEM and the data bus; sub-words via MAU_SUBWORD_EN.
// Latency: minimum 3 cycles per access (launch, BUSY with ack, DONE); timeout after MAX_WAIT BUSY cycles.
// Backpressure: stall holds the pipeline from launch until DONE; bus waits on dmem_ack with held request.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_data,
    output logic        misalign,
    output logic        bus_err
);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lo_q;
    logic        bus_err_q;

    logic        op;
    logic        in_idle;
    logic        in_busy;
    logic        misaligned_c;
    logic        launch;
    logic        timeout;
    logic [3:0]  be_c;
    logic [31:0] lane_c;
    logic [31:0] ld_ext_c;

    mem_align u_align (
        .st_size     (mem_size),
        .st_lo       (addr[1:0]),
        .st_wdata    (wdata),
        .st_be       (be_c),
        .st_lane_dat (lane_c),
        .misaligned  (misaligned_c),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_lo       (lo_q),
        .ld_rdata    (dmem_rdata),
        .ld_ext      (ld_ext_c)
    );

    // A store wins when both read and write are asserted, so any of the two makes an op
    assign op      = ex_valid & (mem_read | mem_write);
    assign in_idle = (state == ST_IDLE);
    assign in_busy = (state == ST_BUSY);
    assign launch  = in_idle & op & ~misaligned_c;
    assign timeout = in_busy & ~dmem_ack & (wait_cnt == 8'(MAX_WAIT - 1));

    // Outputs are gated by reset_n so nothing leaks out while reset is held
    assign stall    = reset_n & (launch | in_busy);
    assign misalign = reset_n & in_idle & op & misaligned_c;
    assign dmem_req = in_busy;
    assign dmem_we  = in_busy & we_q;
    assign bus_err  = bus_err_q;

    // FSM: launch from IDLE, wait for ack or timeout in BUSY, DONE always returns to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (launch) state <= ST_BUSY;
                ST_BUSY: if (dmem_ack || timeout) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Wait counter: number of BUSY cycles already spent on the current request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (in_busy && !dmem_ack && !timeout) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Request registers captured at launch and held stable for the whole BUSY phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            we_q       <= 1'b0;
            size_q     <= SZ_WORD;
            uns_q      <= 1'b0;
            lo_q       <= 2'd0;
        end else if (launch) begin
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= lane_c;
            we_q       <= mem_write;
            size_q     <= mem_size;
            uns_q      <= mem_unsigned;
            lo_q       <= addr[1:0];
        end
    end

    // Load result: extended data on a load ack, zero on timeout, otherwise held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= 32'd0;
        end else if (timeout) begin
            read_data <= 32'd0;
        end else if (in_busy && dmem_ack && !we_q) begin
            read_data <= ld_ext_c;
        end
    end

    // Bus error pulse shows up in the DONE cycle that follows a timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
        end
    end

endmodule
